div_unit: RTL and testbench

- Iterative signed 32-bit divider for the multicycle MIPS datapath.
- The control FSM starts it with a one-cycle div_start pulse, using operands from the A/B registers.
- Produces quotient (LO) and remainder (HI), consumed when HI_write/LO_write are asserted.
- On a zero divisor it raises divzero, which the control FSM uses to enter its divide-by-zero exception state.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/div_step.sv | 33 +++
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants for the multicycle MIPS datapath: default
//                datapath width and the divider state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Datapath width shared by the divider, multiplier and HI/LO muxes
    localparam int WIDTH_DEFAULT = 32;

    // Divider control state encoding
    localparam logic [1:0] DIV_IDLE   = 2'd0;
    localparam logic [1:0] DIV_CALC   = 2'd1;
    localparam logic [1:0] DIV_FINISH = 2'd2;
    localparam logic [1:0] DIV_DZ     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division step. Shifts the next dividend bit
//                into the partial remainder and subtracts the divisor if it
//                fits, producing the next remainder and one quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             msb_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // The shifted remainder is WIDTH+1 bits; one extra bit on top holds the
    // borrow so the sign of the trial subtraction is unambiguous.
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    assign w_diff = {1'b0, rem_in, msb_in} - {2'b00, dvs};
    assign w_fits = ~w_diff[WIDTH+1];

    // The remainder is always below the divisor, so the kept value fits in
    // WIDTH bits in both branches.
    assign rem_out = w_fits ? w_diff[WIDTH-1:0] : {rem_in[WIDTH-2:0], msb_in};
    assign q_bit   = w_fits;

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative signed divider (MIPS DIV semantics). Converts the
//                operands to magnitudes, runs WIDTH restoring steps, then
//                applies signs: quotient truncates toward zero, remainder
//                takes the dividend's sign. A zero divisor is refused with a
//                one-cycle divzero pulse and leaves HI/LO untouched.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_busy,
    output logic             div_done,
    output logic             divzero
);

    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_divzero;

    logic [WIDTH-1:0] w_abs_dividend;
    logic [WIDTH-1:0] w_abs_divisor;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;

    // Magnitudes wrap naturally, so |0x80000000| stays 0x80000000 and is
    // handled correctly as an unsigned value.
    assign w_abs_dividend = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_abs_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (r_rem),
        .msb_in  (r_quo[WIDTH-1]),
        .dvs     (r_dvs),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

    // Control FSM and datapath registers; reset aborts any operation silently
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= DIV_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (div_start) begin
                        if (divisor == '0) begin
                            r_state <= DIV_DZ;
                        end else begin
                            r_state <= DIV_CALC;
                            r_rem   <= '0;
                            r_quo   <= w_abs_dividend;
                            r_dvs   <= w_abs_divisor;
                            r_q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_r_neg <= dividend[WIDTH-1];
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                DIV_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST_STEP) begin
                        r_state <= DIV_FINISH;
                    end
                end
                DIV_FINISH: begin
                    r_lo    <= r_q_neg ? -r_quo : r_quo;
                    r_hi    <= r_r_neg ? -r_rem : r_rem;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DIV_IDLE;
                end
                DIV_DZ: begin
                    r_divzero <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_busy = r_busy;
    assign div_done = r_done;
    assign divzero  = r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking bench for div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_busy;
    logic        div_done;
    logic        divzero;

    int n_pass;
    int n_total;

    div_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .hi        (hi),
        .lo        (lo),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .divzero   (divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Present operands with a one-cycle start pulse (the accepting edge)
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    // Count edges until div_done; also flags a dropout of div_busy or a divzero
    task automatic wait_done(output int edges, output logic busy_ok, output logic dz_seen);
        edges   = 0;
        busy_ok = 1'b1;
        dz_seen = 1'b0;
        while (edges < 60) begin
            tick();
            edges++;
            if (divzero) dz_seen = 1'b1;
            if (div_done) break;
            if (!div_busy) busy_ok = 1'b0;
        end
    endtask

    // Count done/divzero pulses over a quiet window
    task automatic watch(input int n, output int n_done, output int n_dz);
        n_done = 0;
        n_dz   = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (div_done) n_done++;
            if (divzero)  n_dz++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int   edges;
        logic busy_ok;
        logic dz_seen;
        start_div(a, b);
        check({tag, "_busy_start"}, {31'd0, div_busy}, 32'd1);
        wait_done(edges, busy_ok, dz_seen);
        check({tag, "_latency"}, edges, 32'd33);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_no_dz"}, {31'd0, dz_seen}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, div_busy}, 32'd0);
        tick();
        check({tag, "_done_1cyc"}, {31'd0, div_done}, 32'd0);
    endtask

    initial begin
        int   edges;
        int   n_done;
        int   n_dz;
        logic busy_ok;
        logic dz_seen;

        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        div_start = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        tick();
        tick();
        check("rst_hi",   hi, 32'd0);
        check("rst_lo",   lo, 32'd0);
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        check("rst_done", {31'd0, div_done}, 32'd0);
        check("rst_dz",   {31'd0, divzero}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic positive division
        run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        // Sign handling: -7/2 and 7/-2 truncate toward zero
        run_div("dm7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("d7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        // Both negative: -100/-7 = 14 rem -2
        run_div("dm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
        // Overflow case wraps, no flag
        run_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        // Zero dividend
        run_div("d0_5", 32'd0, 32'd5, 32'd0, 32'd0);
        // Largest magnitude divisor: 0x80000000 / 0x80000000 = 1 rem 0
        run_div("dmin_min", 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0);

        // Divide by zero after preloading HI/LO
        run_div("pre_dz", 32'd100, 32'd7, 32'd14, 32'd2);
        start_div(32'd100, 32'd0);
        check("dz_k_flag", {31'd0, divzero}, 32'd0);
        check("dz_k_busy", {31'd0, div_busy}, 32'd0);
        tick();
        check("dz_k1_flag", {31'd0, divzero}, 32'd1);
        check("dz_k1_busy", {31'd0, div_busy}, 32'd0);
        check("dz_k1_done", {31'd0, div_done}, 32'd0);
        watch(40, n_done, n_dz);
        check("dz_no_done", n_done, 32'd0);
        check("dz_one_pulse", n_dz, 32'd0);
        check("dz_hi_kept", hi, 32'd2);
        check("dz_lo_kept", lo, 32'd14);

        // Start while busy is ignored
        run_div("pre_ovl", 32'd9, 32'd3, 32'd3, 32'd0);
        start_div(32'd100, 32'd7);
        repeat (9) tick();
        start_div(32'd50, 32'd5);
        wait_done(edges, busy_ok, dz_seen);
        check("ovl_latency", edges, 32'd23);
        check("ovl_lo", lo, 32'd14);
        check("ovl_hi", hi, 32'd2);
        check("ovl_busy_held", {31'd0, busy_ok}, 32'd1);
        watch(40, n_done, n_dz);
        check("ovl_extra_done", n_done, 32'd0);
        check("ovl_busy_end", {31'd0, div_busy}, 32'd0);

        // Start on the FINISH edge is ignored
        start_div(32'd100, 32'd7);
        repeat (32) tick();
        start_div(32'd50, 32'd5);
        check("fin_done", {31'd0, div_done}, 32'd1);
        check("fin_lo", lo, 32'd14);
        watch(40, n_done, n_dz);
        check("fin_ignored", n_done, 32'd0);

        // Mid-division reset aborts with no result or flag
        start_div(32'd100, 32'd7);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_hi",   hi, 32'd0);
        check("mrst_lo",   lo, 32'd0);
        check("mrst_busy", {31'd0, div_busy}, 32'd0);
        watch(40, n_done, n_dz);
        check("mrst_no_done", n_done, 32'd0);
        check("mrst_no_dz",   n_dz, 32'd0);
        run_div("post_rst", 32'd9, 32'd3, 32'd3, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
